// File: rtl/lif_array_sched.sv
// lif_array_sched: one shared leaky integrate-and-fire datapath serving
// N_NEURONS virtual neurons. A timestep updates one neuron per cycle in index
// order, then pulses step_done for one cycle.
//
// Handshake: step_start is a single-cycle request. It is taken only in IDLE.
// While busy is high it is ignored, and it is neither queued nor counted.
// step_done is high for exactly one cycle. spk_vec is valid in that cycle and
// holds its value until the next timestep updates it.
module lif_array_sched #(
  parameter int N_NEURONS = 8,
  parameter int IDX_W     = $clog2(N_NEURONS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic             cfg_addr,
  input  logic [7:0]       cfg_wdata,
  input  logic             cur_we,
  input  logic [IDX_W-1:0] cur_idx,
  input  logic [7:0]       cur_data,
  input  logic             step_start,
  output logic             busy,
  output logic             step_done,
  output logic [N_NEURONS-1:0] spk_vec,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             upd_en;

  logic [7:0] state_mem [N_NEURONS];
  logic [7:0] cur_mem   [N_NEURONS];
  logic [7:0] threshold;
  logic [7:0] beta;

  // Shared datapath signals for the neuron selected by idx_q.
  logic [15:0] prod;
  logic [12:0] sum;
  logic [7:0]  nxt;
  logic        fire;

  // Register the FSM state and the neuron pointer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm_q <= IDLE;
      idx_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      idx_q <= idx_d;
    end
  end

  // Compute the next FSM state, the next pointer and the status outputs.
  always_comb begin
    fsm_d     = fsm_q;
    idx_d     = idx_q;
    upd_en    = 1'b0;
    busy      = 1'b0;
    step_done = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (step_start) begin
          fsm_d = UPDATE;
          idx_d = '0;
        end
      end
      UPDATE: begin
        busy   = 1'b1;
        upd_en = 1'b1;
        if (idx_q == IDX_W'(N_NEURONS - 1)) begin
          fsm_d = DONE;
          idx_d = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        busy      = 1'b1;
        step_done = 1'b1;
        fsm_d     = IDLE;
      end
      default: begin
        fsm_d = IDLE;
        idx_d = '0;
      end
    endcase
  end

  // LIF update: leak by the Q4.4 factor beta, add the current, saturate
  // at 255, then fire when the result reaches the threshold.
  always_comb begin
    prod = beta * state_mem[idx_q];
    sum  = {5'd0, cur_mem[idx_q]} + {1'b0, prod[15:4]};
    nxt  = (sum > 13'd255) ? 8'd255 : sum[7:0];
    fire = (nxt >= threshold);
  end

  // Config registers. Writes are dropped while a timestep is running, so
  // every neuron in a step sees the same threshold and beta.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      threshold <= 8'd200;
      beta      <= 8'd10;
    end else if (cfg_we && !busy) begin
      if (cfg_addr) beta      <= cfg_wdata;
      else          threshold <= cfg_wdata;
    end
  end

  // Input currents. Writes are accepted in any state. A write to the neuron
  // being updated lands at the same edge, so this step uses the old value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N_NEURONS; i++) cur_mem[i] <= 8'd0;
    end else if (cur_we) begin
      cur_mem[cur_idx] <= cur_data;
    end
  end

  // Membrane state and spike flags, written for one neuron per UPDATE cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N_NEURONS; i++) state_mem[i] <= 8'd0;
      spk_vec <= '0;
    end else if (upd_en) begin
      state_mem[idx_q] <= fire ? 8'd0 : nxt;
      spk_vec[idx_q]   <= fire;
    end
  end

  // Registered readback. It shows the state as of the previous edge and does
  // not bypass a write made at the same edge.
  always_ff @(posedge clk) begin
    if (!reset_n) rd_data <= 8'd0;
    else          rd_data <= state_mem[rd_idx];
  end

endmodule

// File: tb/tb_lif_array_sched.sv
// Directed testbench for lif_array_sched (N_NEURONS = 8).
module tb_lif_array_sched;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cfg_we;
  logic         cfg_addr;
  logic [7:0]   cfg_wdata;
  logic         cur_we;
  logic [W-1:0] cur_idx;
  logic [7:0]   cur_data;
  logic         step_start;
  logic         busy;
  logic         step_done;
  logic [N-1:0] spk_vec;
  logic [W-1:0] rd_idx;
  logic [7:0]   rd_data;

  int total = 0;
  int bad   = 0;

  lif_array_sched #(.N_NEURONS(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cur_we     (cur_we),
    .cur_idx    (cur_idx),
    .cur_data   (cur_data),
    .step_start (step_start),
    .busy       (busy),
    .step_done  (step_done),
    .spk_vec    (spk_vec),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    cfg_we     = 1'b0;
    cfg_addr   = 1'b0;
    cfg_wdata  = 8'd0;
    cur_we     = 1'b0;
    cur_idx    = '0;
    cur_data   = 8'd0;
    step_start = 1'b0;
    rd_idx     = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic cfg_write(input logic a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic cur_write(input int i, input logic [7:0] d);
    cur_we = 1'b1; cur_idx = W'(i); cur_data = d;
    tick();
    cur_we = 1'b0;
  endtask

  task automatic read_state(input int i, output logic [7:0] v);
    rd_idx = W'(i);
    tick();
    v = rd_data;
  endtask

  // Run one timestep. inj selects a disturbance driven during cycle t+inj_c:
  // 1 = step_start plus a threshold write, 2 = write cur[2] = 100.
  task automatic run_step(input int inj, input int inj_c, output logic [7:0] spk);
    int c;
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    c = 1;
    chk("busy_rise", busy, 1);
    while (!step_done && c < 20) begin
      if (c == inj_c && inj == 1) begin
        step_start = 1'b1; cfg_we = 1'b1; cfg_addr = 1'b0; cfg_wdata = 8'd1;
      end else if (c == inj_c && inj == 2) begin
        cur_we = 1'b1; cur_idx = 3'd2; cur_data = 8'd100;
      end
      tick();
      step_start = 1'b0; cfg_we = 1'b0; cur_we = 1'b0;
      c++;
    end
    chk("done_latency", c, 9);
    spk = spk_vec;
    tick();
    chk("busy_fall", busy, 0);
    chk("done_fall", step_done, 0);
  endtask

  logic [7:0] v;
  logic [7:0] spk;
  logic [7:0] exp_s3 [4];
  logic [7:0] exp_s0 [4];
  logic       saw_done;

  initial begin
    exp_s3[0] = 8'd50;  exp_s3[1] = 8'd100; exp_s3[2] = 8'd150; exp_s3[3] = 8'd0;
    exp_s0[0] = 8'd50;  exp_s0[1] = 8'd81;  exp_s0[2] = 8'd100; exp_s0[3] = 8'd112;

    // Reset state.
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_done", step_done, 0);
    chk("rst_spk", spk_vec, 0);
    chk("rst_rd", rd_data, 0);
    for (int i = 0; i < N; i++) begin
      read_state(i, v);
      chk("rst_state", v, 0);
    end
    run_step(0, 0, spk);
    chk("zero_cur_spk", spk, 8'h00);

    // Integrate with no leak: 50, 100, 150, then fire at 200.
    do_reset();
    cfg_write(1'b1, 8'd16);
    cur_write(3, 8'd50);
    for (int s = 0; s < 4; s++) begin
      run_step(0, 0, spk);
      chk("b16_spk", spk, (s == 3) ? 8'h08 : 8'h00);
      read_state(3, v);
      chk("b16_state3", v, exp_s3[s]);
    end

    // Default leak beta = 10: 50, 81, 100, 112.
    do_reset();
    cur_write(0, 8'd50);
    for (int s = 0; s < 4; s++) begin
      run_step(0, 0, spk);
      chk("b10_spk", spk, 8'h00);
      read_state(0, v);
      chk("b10_state0", v, exp_s0[s]);
    end

    // Saturation and threshold at the top of the range.
    do_reset();
    cfg_write(1'b1, 8'd255);
    cfg_write(1'b0, 8'd255);
    cur_write(7, 8'd255);
    run_step(0, 0, spk);
    chk("sat_spk", spk, 8'h80);
    read_state(7, v);
    chk("sat_state7", v, 0);
    // 200 then 200 + (255*200 >> 4) clamps to 255, which reaches 255.
    cur_write(7, 8'd200);
    run_step(0, 0, spk);
    chk("clamp_spk1", spk, 8'h00);
    read_state(7, v);
    chk("clamp_state1", v, 200);
    run_step(0, 0, spk);
    chk("clamp_spk2", spk, 8'h80);
    read_state(7, v);
    chk("clamp_state2", v, 0);
    // Threshold 0: everything fires every step.
    cfg_write(1'b0, 8'd0);
    for (int s = 0; s < 2; s++) begin
      run_step(0, 0, spk);
      chk("thr0_spk", spk, 8'hFF);
    end
    read_state(7, v);
    chk("thr0_state7", v, 0);

    // step_start and cfg write while busy are dropped.
    do_reset();
    cur_write(1, 8'd150);
    run_step(1, 1, spk);
    chk("busy_drop_spk", spk, 8'h00);
    tick();
    tick();
    chk("no_second_step", busy, 0);
    read_state(1, v);
    chk("busy_drop_state1", v, 150);

    // cur write in the cycle neuron 2 updates: old value now, new value next.
    do_reset();
    cur_write(2, 8'd20);
    run_step(2, 3, spk);
    read_state(2, v);
    chk("curwr_old", v, 20);
    run_step(0, 0, spk);
    read_state(2, v);
    chk("curwr_new", v, 112);

    // Same-cycle cur write and step_start in IDLE: the new current is used.
    do_reset();
    cur_we = 1'b1; cur_idx = 3'd5; cur_data = 8'd77;
    run_step(0, 0, spk);
    read_state(5, v);
    chk("wr_with_start", v, 77);

    // Reset in the middle of UPDATE.
    do_reset();
    cur_write(3, 8'd50);
    run_step(0, 0, spk);
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("midrst_busy", busy, 0);
    saw_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (step_done) saw_done = 1'b1;
      tick();
    end
    chk("midrst_no_done", saw_done, 0);
    chk("midrst_spk", spk_vec, 0);
    for (int i = 0; i < N; i++) begin
      read_state(i, v);
      chk("midrst_state", v, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lif_array_sched.md
# lif_array_sched

Time-multiplexed scheduler that shares a single leaky integrate-and-fire (LIF) update datapath across `N_NEURONS` virtual neurons. It holds the per-neuron membrane state and input current, and the shared threshold and decay configuration. On each `step_start` it sequences one update per neuron per cycle and reports the resulting spike vector. It sits between the host/config interface and downstream spike consumers, replacing N parallel single-neuron instances.

## Interface
Parameters:
- `N_NEURONS`, default 8: number of virtual neurons; must be a power of 2, range 2..64.
- `IDX_W`, default `$clog2(N_NEURONS)`: neuron index width.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `cfg_we`  in  1  config write strobe.
- `cfg_addr`  in  1  config address: 0 = threshold, 1 = beta.
- `cfg_wdata`  in  8  config write data.
- `cur_we`  in  1  current write strobe.
- `cur_idx`  in  IDX_W  neuron index for the current write.
- `cur_data`  in  8  input current for neuron `cur_idx`.
- `step_start`  in  1  request one timestep update of all neurons.
- `busy`  out  1  timestep in progress.
- `step_done`  out  1  one-cycle pulse when the timestep completes.
- `spk_vec`  out  N_NEURONS  spike flags from the most recent timestep.
- `rd_idx`  in  IDX_W  state readback index.
- `rd_data`  out  8  registered `state[rd_idx]`.

## Operation
- Storage: `state[N]` (8b), `cur[N]` (8b), `threshold` (8b), `beta` (8b, unsigned Q4.4, so 16 = 1.0).
- Reset values: all `state` = 0, all `cur` = 0, `threshold` = 200, `beta` = 10, `spk_vec` = 0, `busy` = 0, `step_done` = 0, `rd_data` = 0, FSM = IDLE, `idx` = 0.
- Update for neuron i:
  - `prod = beta*state[i]` (16b).
  - `sum = cur[i] + (prod >> 4)` (13b).
  - `nxt = (sum > 255) ? 255 : sum`.
  - `fire = (nxt >= threshold)`, unsigned compare.
  - `state[i] <= fire ? 0 : nxt`.
  - `spk_vec[i] <= fire`.
- FSM states:
  - IDLE: `step_start` = 1 → UPDATE with `idx` = 0.
  - UPDATE: process neuron `idx`. If `idx` == N-1 → DONE, else `idx` + 1.
  - DONE: `step_done` = 1 → IDLE.
- `busy` = 1 in UPDATE and DONE. `step_start` is ignored while busy; requests are neither queued nor counted.
- `spk_vec` bits update individually as each neuron is processed and hold between steps. Consumers sample `spk_vec` on `step_done`.
- `cfg_we` while busy: the write is dropped. The config stays constant within a step. A write to an unused `cfg_addr` value (none exist at width 1) is not applicable.
- `cur_we` is accepted in any state. If it targets the neuron being processed in the same cycle, the update uses the old `cur` value and the new value is stored for the next step.
- `cur_we` and `step_start` in the same IDLE cycle: the write lands first, and neuron updates use the new value.
- `threshold` = 0: every neuron fires every step and state stays 0.
- Reset mid-step: the FSM returns to IDLE, all storage is reinitialised, and no `step_done` is emitted.

## Timing
- `step_start` sampled in IDLE at cycle t: neuron k updates at the clock edge ending cycle t+1+k.
- `step_done` is high during cycle t+N+1. The FSM is back in IDLE at t+N+2, and a new `step_start` is accepted at t+N+2.
- A step occupies N+2 cycles total.
- `busy` rises at t+1 and falls at t+N+2.
- `rd_data` has 1-cycle latency from `rd_idx`. It reflects state after the preceding edge; no bypass of the same-edge write.
- Config and current writes take effect at the next edge.

## Test plan
- Reset, then read all indices → `rd_data` = 0, `spk_vec` = 0, `busy` = 0. A step with `cur` = 0 → no spikes, and `step_done` is seen exactly 9 cycles after `step_start` (N = 8, step_start at t, step_done during t+N+1).
- `beta` = 16, `cur[3]` = 50, others 0, `threshold` = 200. Run four steps → state[3] reads 50, 100, 150, then 0 with `spk_vec` = 0x08 only on step 4.
- `beta` = 10, `cur[0]` = 50. Run steps → state[0] reads 50, 81, 100, 112, with no spike.
- Saturation: `beta` = 255, `cur[7]` = 255, `threshold` = 255 → step 1 gives state 0 and a spike (255 ≥ 255). With `threshold` = 0 → all bits of `spk_vec` set each step.
- Pulse `step_start` and `cfg_we` (threshold = 1) during busy → no second step, threshold still 200. Write `cur[2]` in the cycle neuron 2 updates → old value used this step, new value used next step.
- Assert `reset_n` = 0 mid-UPDATE → next cycle `busy` = 0, no `step_done`, all states read 0.
